// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with majority-vote bit decisions, sticky error flags,
// break/idle-timeout detection and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     BAUD_TICK,
    input  logic                     RX,
    input  logic [1:0]               DATA_BITS,
    input  logic                     PARITY_EN,
    input  logic                     ODD_N_EVEN,
    input  logic                     TWO_STOP,
    input  logic                     RD_EN,
    input  logic                     ERR_CLR,
    output logic [7:0]               DATA_OUT,
    output logic                     RXRDY,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVERFLOW,
    output logic                     PARITY_ERR,
    output logic                     FRAMING_ERR,
    output logic                     BREAK_DET,
    output logic                     TIMEOUT
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned LVL_W    = PTR_W + 1;
    localparam int unsigned TICK_W   = $clog2(OVERSAMPLE);
    localparam int unsigned MID      = OVERSAMPLE / 2;
    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2
    } state_t;

    state_t              state, state_nxt;
    logic                rx_s1, rx_s2;
    logic [TICK_W-1:0]   tick_cnt, tick_nxt;
    logic [2:0]          bit_cnt, bit_nxt;
    logic [7:0]          shreg, shreg_nxt;
    logic                samp0, samp0_nxt, samp1, samp1_nxt;
    logic                par_acc, par_nxt;
    logic                any_one, ones_nxt;
    logic                brk_wait, brk_nxt;
    logic [1:0]          cfg_bits, cfg_bits_nxt;
    logic                cfg_par, cfg_par_nxt, cfg_odd, cfg_odd_nxt, cfg_two, cfg_two_nxt;

    logic                maj, dec, wrap, par_bad;
    logic [2:0]          last_bit;
    logic                commit_c, set_par_c, set_frm_c, set_brk_c;

    logic [7:0]          mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
    logic [LVL_W-1:0]    level_nxt;
    logic [7:0]          head_nxt;
    logic                rd_c, wr_c, ovf_c;
    logic [TO_W-1:0]     to_cnt, to_nxt;

    // Receiver state and datapath registers
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            samp0    <= 1'b0;
            samp1    <= 1'b0;
            par_acc  <= 1'b0;
            any_one  <= 1'b0;
            brk_wait <= 1'b0;
            cfg_bits <= '0;
            cfg_par  <= 1'b0;
            cfg_odd  <= 1'b0;
            cfg_two  <= 1'b0;
        end else begin
            rx_s1    <= RX;
            rx_s2    <= rx_s1;
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            samp0    <= samp0_nxt;
            samp1    <= samp1_nxt;
            par_acc  <= par_nxt;
            any_one  <= ones_nxt;
            brk_wait <= brk_nxt;
            cfg_bits <= cfg_bits_nxt;
            cfg_par  <= cfg_par_nxt;
            cfg_odd  <= cfg_odd_nxt;
            cfg_two  <= cfg_two_nxt;
        end
    end

    // Frame decoding: bit decisions at MID+1, bit boundaries at tick wrap
    always_comb begin
        state_nxt    = state;
        tick_nxt     = tick_cnt;
        bit_nxt      = bit_cnt;
        shreg_nxt    = shreg;
        samp0_nxt    = samp0;
        samp1_nxt    = samp1;
        par_nxt      = par_acc;
        ones_nxt     = any_one;
        brk_nxt      = brk_wait;
        cfg_bits_nxt = cfg_bits;
        cfg_par_nxt  = cfg_par;
        cfg_odd_nxt  = cfg_odd;
        cfg_two_nxt  = cfg_two;
        commit_c     = 1'b0;
        set_par_c    = 1'b0;
        set_frm_c    = 1'b0;
        set_brk_c    = 1'b0;

        maj      = (samp0 & samp1) | (samp0 & rx_s2) | (samp1 & rx_s2);
        dec      = BAUD_TICK && (tick_cnt == TICK_W'(MID + 1));
        wrap     = BAUD_TICK && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
        par_bad  = cfg_par && (par_acc != cfg_odd);
        last_bit = {1'b0, cfg_bits} + 3'd4;

        if (BAUD_TICK && state != IDLE) begin
            tick_nxt = tick_cnt + 1'b1;
            if (tick_cnt == TICK_W'(MID - 1)) samp0_nxt = rx_s2;
            if (tick_cnt == TICK_W'(MID))     samp1_nxt = rx_s2;
        end

        case (state)
            IDLE: begin
                if (BAUD_TICK && !rx_s2) begin
                    state_nxt    = START;
                    tick_nxt     = '0;
                    bit_nxt      = '0;
                    shreg_nxt    = '0;
                    par_nxt      = 1'b0;
                    ones_nxt     = 1'b0;
                    cfg_bits_nxt = DATA_BITS;
                    cfg_par_nxt  = PARITY_EN;
                    cfg_odd_nxt  = ODD_N_EVEN;
                    cfg_two_nxt  = TWO_STOP;
                end
            end
            START: begin
                if (dec && maj)  state_nxt = IDLE;
                else if (wrap)   state_nxt = DATA;
            end
            DATA: begin
                if (dec) begin
                    shreg_nxt[bit_cnt] = maj;
                    par_nxt            = par_acc ^ maj;
                    ones_nxt           = any_one | maj;
                end
                if (wrap) begin
                    if (bit_cnt == last_bit) state_nxt = cfg_par ? PARITY : STOP1;
                    else                     bit_nxt   = bit_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (dec) begin
                    par_nxt  = par_acc ^ maj;
                    ones_nxt = any_one | maj;
                end
                if (wrap) state_nxt = STOP1;
            end
            STOP1: begin
                // After a break, hold here until the line returns high
                if (brk_wait) begin
                    if (rx_s2) begin
                        brk_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end
                end else if (dec) begin
                    if (!maj && !any_one) begin
                        set_brk_c = 1'b1;
                        brk_nxt   = 1'b1;
                    end else if (!maj) begin
                        set_frm_c = 1'b1;
                        state_nxt = IDLE;
                    end else if (par_bad) begin
                        set_par_c = 1'b1;
                        state_nxt = IDLE;
                    end else if (!cfg_two) begin
                        commit_c  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (wrap) begin
                    state_nxt = STOP2;
                end
            end
            STOP2: begin
                if (dec) begin
                    if (!maj) set_frm_c = 1'b1;
                    else      commit_c  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO pointer/level/head and idle-timeout next-state
    always_comb begin
        rd_c       = RD_EN && (LEVEL != '0);
        wr_c       = commit_c && (!FULL || rd_c);
        ovf_c      = commit_c && FULL && !rd_c;
        wr_ptr_nxt = wr_c ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr_nxt = rd_c ? rd_ptr + 1'b1 : rd_ptr;
        case ({wr_c, rd_c})
            2'b10:   level_nxt = LEVEL + LVL_W'(1);
            2'b01:   level_nxt = LEVEL - LVL_W'(1);
            default: level_nxt = LEVEL;
        endcase
        // New head may be the byte being written this cycle
        if (level_nxt == '0)                    head_nxt = '0;
        else if (wr_c && rd_ptr_nxt == wr_ptr)  head_nxt = shreg;
        else                                    head_nxt = mem[rd_ptr_nxt];

        to_nxt = to_cnt;
        if (rd_c || commit_c || state != IDLE)
            to_nxt = '0;
        else if (BAUD_TICK && LEVEL != '0 && to_cnt != TO_W'(TO_LIMIT))
            to_nxt = to_cnt + 1'b1;
    end

    // FIFO storage; contents are don't-care after reset
    always_ff @(posedge CLK) begin
        if (RESET_N && wr_c) mem[wr_ptr] <= shreg;
    end

    // FIFO state, registered outputs and sticky flags
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            LEVEL       <= '0;
            DATA_OUT    <= '0;
            RXRDY       <= 1'b0;
            FULL        <= 1'b0;
            to_cnt      <= '0;
            TIMEOUT     <= 1'b0;
            OVERFLOW    <= 1'b0;
            PARITY_ERR  <= 1'b0;
            FRAMING_ERR <= 1'b0;
            BREAK_DET   <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            LEVEL       <= level_nxt;
            DATA_OUT    <= head_nxt;
            RXRDY       <= (level_nxt != '0);
            FULL        <= (level_nxt == LVL_W'(DEPTH));
            to_cnt      <= to_nxt;
            TIMEOUT     <= (to_nxt == TO_W'(TO_LIMIT));
            OVERFLOW    <= ovf_c     | (OVERFLOW    & ~ERR_CLR);
            PARITY_ERR  <= set_par_c | (PARITY_ERR  & ~ERR_CLR);
            FRAMING_ERR <= set_frm_c | (FRAMING_ERR & ~ERR_CLR);
            BREAK_DET   <= set_brk_c | (BREAK_DET   & ~ERR_CLR);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: DEPTH=4, OVERSAMPLE=16, TIMEOUT_BITS=4, tick every cycle.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned OS    = 16;
    localparam int unsigned TOB   = 4;

    logic       CLK = 1'b0;
    logic       RESET_N, BAUD_TICK, RX;
    logic [1:0] DATA_BITS;
    logic       PARITY_EN, ODD_N_EVEN, TWO_STOP, RD_EN, ERR_CLR;
    logic [7:0] DATA_OUT;
    logic       RXRDY, FULL;
    logic [2:0] LEVEL;
    logic       OVERFLOW, PARITY_ERR, FRAMING_ERR, BREAK_DET, TIMEOUT;

    int n_vec = 0;
    int n_err = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .OVERSAMPLE(OS), .TIMEOUT_BITS(TOB)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .BAUD_TICK(BAUD_TICK), .RX(RX),
        .DATA_BITS(DATA_BITS), .PARITY_EN(PARITY_EN), .ODD_N_EVEN(ODD_N_EVEN),
        .TWO_STOP(TWO_STOP), .RD_EN(RD_EN), .ERR_CLR(ERR_CLR),
        .DATA_OUT(DATA_OUT), .RXRDY(RXRDY), .FULL(FULL), .LEVEL(LEVEL),
        .OVERFLOW(OVERFLOW), .PARITY_ERR(PARITY_ERR), .FRAMING_ERR(FRAMING_ERR),
        .BREAK_DET(BREAK_DET), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {OVERFLOW, PARITY_ERR, FRAMING_ERR, BREAK_DET};
    endfunction

    task automatic set_cfg(input logic [1:0] db, input logic pe, input logic odd, input logic two);
        DATA_BITS  = db;
        PARITY_EN  = pe;
        ODD_N_EVEN = odd;
        TWO_STOP   = two;
    endtask

    // One frame, OS cycles per bit, followed by idle line
    task automatic send_frame(input logic [7:0] d, input int nb, input logic pe, input logic pbit,
                              input logic st1, input logic st2, input logic two);
        @(posedge CLK); #1 RX = 1'b0;
        repeat (OS) @(posedge CLK);
        for (int i = 0; i < nb; i++) begin
            #1 RX = d[i];
            repeat (OS) @(posedge CLK);
        end
        if (pe) begin
            #1 RX = pbit;
            repeat (OS) @(posedge CLK);
        end
        #1 RX = st1;
        repeat (OS) @(posedge CLK);
        if (two) begin
            #1 RX = st2;
            repeat (OS) @(posedge CLK);
        end
        #1 RX = 1'b1;
        repeat (OS) @(posedge CLK);
    endtask

    task automatic pop();
        @(posedge CLK); #1 RD_EN = 1'b1;
        @(posedge CLK); #1 RD_EN = 1'b0;
    endtask

    task automatic clr();
        @(posedge CLK); #1 ERR_CLR = 1'b1;
        @(posedge CLK); #1 ERR_CLR = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0; BAUD_TICK = 1'b1; RX = 1'b1; RD_EN = 1'b0; ERR_CLR = 1'b0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_outputs", {DATA_OUT, RXRDY, FULL, LEVEL, flags(), TIMEOUT}, 32'h0);
        @(posedge CLK); #1 RESET_N = 1'b1;
        repeat (4) @(posedge CLK);

        // 8N1 0xA5: commit latency, then idle timeout of 64 ticks
        fork
            send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            begin
                @(posedge CLK);
                repeat (156) @(posedge CLK);
                @(negedge CLK);
                check("a5_rxrdy_before", RXRDY, 1'b0);
                @(negedge CLK);
                check("a5_rxrdy", RXRDY, 1'b1);
                check("a5_data", DATA_OUT, 8'hA5);
                check("a5_level", LEVEL, 3'd1);
                check("a5_flags", flags(), 4'h0);
                repeat (63) @(negedge CLK);
                check("timeout_63", TIMEOUT, 1'b0);
                @(negedge CLK);
                check("timeout_64", TIMEOUT, 1'b1);
            end
        join
        pop();
        @(negedge CLK);
        check("timeout_read", {TIMEOUT, RXRDY, LEVEL, DATA_OUT}, 32'h0);

        // 7E2 frames of 0x35 (four ones in 7 bits: even parity bit = 0)
        set_cfg(2'b10, 1'b1, 1'b0, 1'b1);
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge CLK);
        check("par_err_flags", flags(), 4'b0100);
        check("par_err_level", LEVEL, 3'd0);
        clr();
        @(negedge CLK);
        check("par_err_clear", flags(), 4'h0);
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        check("stop2_frm_flags", flags(), 4'b0010);
        check("stop2_frm_level", LEVEL, 3'd0);
        clr();
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge CLK);
        check("7e2_good", {flags(), LEVEL, DATA_OUT}, {4'h0, 3'd1, 8'h35});
        pop();

        // Short glitch is a false start
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1 RX = 1'b0;
        repeat (4) @(posedge CLK);
        #1 RX = 1'b1;
        repeat (40) @(posedge CLK);
        @(negedge CLK);
        check("glitch", {flags(), RXRDY, LEVEL}, 32'h0);

        // Line low for 12 bit-times
        @(posedge CLK); #1 RX = 1'b0;
        repeat (12 * OS) @(posedge CLK);
        #1 RX = 1'b1;
        repeat (20) @(posedge CLK);
        @(negedge CLK);
        check("break_flags", flags(), 4'b0001);
        check("break_level", LEVEL, 3'd0);
        clr();

        // Five bytes into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        check("ovf_full", {FULL, LEVEL}, {1'b1, 3'd4});
        check("ovf_flags", flags(), 4'b1000);
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            check("ovf_read", DATA_OUT, 32'(i));
            pop();
        end
        @(negedge CLK);
        check("ovf_drained", {RXRDY, LEVEL, DATA_OUT}, 32'h0);
        clr();

        // Fifth commit with RD_EN in the same cycle
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        fork
            send_frame(8'h05, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            begin
                @(posedge CLK);
                repeat (156) @(posedge CLK);
                #1 RD_EN = 1'b1;
                @(posedge CLK);
                #1 RD_EN = 1'b0;
            end
        join
        @(negedge CLK);
        check("rw_full_level", {FULL, LEVEL}, {1'b1, 3'd4});
        check("rw_full_flags", flags(), 4'h0);
        for (int i = 2; i <= 5; i++) begin
            @(negedge CLK);
            check("rw_read", DATA_OUT, 32'(i));
            pop();
        end

        // Reset mid-DATA with two bytes queued and a framing error pending
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        check("pre_reset", {flags(), LEVEL, DATA_OUT}, {4'b0010, 3'd2, 8'h11});
        fork
            send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            begin
                @(posedge CLK);
                repeat (60) @(posedge CLK);
                #1 RESET_N = 1'b0;
                @(posedge CLK);
                #1 RESET_N = 1'b1;
                @(negedge CLK);
                check("mid_reset", {DATA_OUT, RXRDY, FULL, LEVEL, flags(), TIMEOUT}, 32'h0);
            end
        join
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        check("post_reset_3c", {flags(), RXRDY, LEVEL, DATA_OUT}, {4'h0, 1'b1, 3'd1, 8'h3C});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
